dt_peak_scan: RTL
=================

DT_PEAK_SCAN -- requirements
Module: dt_peak_scan

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, level request, driven by the distance-transform stage's done.
REQ-004 SHALL have port res_rd, output, 1, read strobe to the 128x128 byte result RAM.
REQ-005 SHALL have port res_addr, output, 14, RAM address in raster order (row*128+col).
REQ-006 SHALL have port res_di, input, 8, RAM read data, valid the cycle after res_addr/res_rd are registered.
REQ-007 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-008 SHALL have port valid, output, 1, results stable and complete.
REQ-009 SHALL have port max_val, output, 8, largest distance value found.
REQ-010 SHALL have ports max_row and max_col, output, 7 each, coordinates of first pixel holding max_val.
REQ-011 SHALL have port obj_cnt, output, 15, number of nonzero pixels (0..16384).

Function
REQ-012 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-013 IDLE->SCAN when start=1 and armed=1; same edge: res_rd=1, res_addr=0, busy=1, valid=0, all results and accumulators cleared.
REQ-014 SCAN SHALL increment res_addr by 1 each cycle with res_rd=1; at the edge res_addr goes 16382->16383, next state is DRAIN.
REQ-015 DRAIN SHALL drop res_rd to 0, hold res_addr at 16383, consume the last datum, then enter DONE.
REQ-016 Datum for address n SHALL be accumulated at the edge following the edge that issued n; exactly 16384 data accumulated, none twice.
REQ-017 max update only on res_di strictly greater than current max_val; ties keep the earlier raster position; row/col taken from the datum's address (addr[13:7], addr[6:0]).
REQ-018 obj_cnt SHALL increment on every res_di != 0; 15-bit, no saturation needed (max 16384).
REQ-019 On entry to DONE: busy=0, valid=1; valid asserted exactly 16385 cycles after the edge that sampled start in IDLE.
REQ-020 DONE SHALL hold results and valid; armed cleared on scan start and set again only when start is sampled 0; DONE->IDLE on start=0 (valid stays 1 in IDLE until next scan starts).
REQ-021 start held high continuously SHALL produce exactly one scan; start changes during SCAN/DRAIN SHALL be ignored.
REQ-022 All-zero image SHALL yield max_val=0, max_row=0, max_col=0, obj_cnt=0.

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE, armed=1, res_rd=0, res_addr=0, busy=0, valid=0, max_val=0, max_row=0, max_col=0, obj_cnt=0 (and sum=0 if present).
REQ-024 Reset mid-scan SHALL abort with no partial result visible; first start=1 after release begins a fresh full scan.

Configuration
REQ-025 Macro DT_PEAK_SUM_EN defined: extra output port sum_val, 22 bits, sum of all 16384 res_di values, cleared at scan start, valid with valid.
REQ-026 Macro undefined: no sum_val port, no adder; all other behaviour and timing identical.

Verification
REQ-027 RAM all zero, start pulse -> valid after 16385 cycles; max_val=0, row=col=0, obj_cnt=0.
REQ-028 RAM zero except addr 5*128+9 = 7 -> max_val=7, max_row=5, max_col=9, obj_cnt=1.
REQ-029 value 12 at (3,100) and (90,4), others 1 -> max (3,100), obj_cnt=16384; with DT_PEAK_SUM_EN sum_val=16384-2+24=16406.
REQ-030 start held high 40000 cycles -> exactly one scan; lower then raise -> second scan, valid drops on restart edge.
REQ-031 reset asserted at res_addr=8000, released, start -> full scan from addr 0, correct results.
REQ-032 res_rd high for exactly 16384 cycles per scan, res_addr sequence 0..16383 with no gaps.

Source files
------------

// File: rtl/dt_peak_scan.sv
// Raster-scans the 128x128 distance-transform result RAM, reporting the peak value, its first location and the nonzero count.
// Optional: define DT_PEAK_SUM_EN to add a 22-bit sum_val output accumulating every pixel value.
module dt_peak_scan (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  max_val,
    output logic [6:0]  max_row,
    output logic [6:0]  max_col,
    output logic [14:0] obj_cnt
`ifdef DT_PEAK_SUM_EN
   ,output logic [21:0] sum_val
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      state_q;
    logic        armed_q;
    logic        rd_q;
    logic [13:0] addr_q;
    logic        busy_q;
    logic        valid_q;
    logic [7:0]  maxVal_q;
    logic [6:0]  maxRow_q;
    logic [6:0]  maxCol_q;
    logic [14:0] objCnt_q;

    logic        newPeak_d;
    logic        nonZero_d;
    logic [14:0] objCnt_d;

    assign newPeak_d = (res_di > maxVal_q);
    assign nonZero_d = (res_di != 8'd0);
    assign objCnt_d  = objCnt_q + 15'd1;

`ifdef DT_PEAK_SUM_EN
    logic [21:0] sum_q;
    logic [21:0] sum_d;

    assign sum_d   = sum_q + {14'd0, res_di};
    assign sum_val = sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= 22'd0;
        end else if (state_q == IDLE && start && armed_q) begin
            sum_q <= 22'd0;
        end else if (rd_q) begin
            sum_q <= sum_d;
        end
    end
`endif

    // rd_q high means res_di carries the datum for addr_q this cycle, so it doubles as the accumulate enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            armed_q  <= 1'b1;
            rd_q     <= 1'b0;
            addr_q   <= 14'd0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            maxVal_q <= 8'd0;
            maxRow_q <= 7'd0;
            maxCol_q <= 7'd0;
            objCnt_q <= 15'd0;
        end else begin
            if (!start) begin
                armed_q <= 1'b1;
            end

            if (rd_q) begin
                if (newPeak_d) begin
                    maxVal_q <= res_di;
                    maxRow_q <= addr_q[13:7];
                    maxCol_q <= addr_q[6:0];
                end
                if (nonZero_d) begin
                    objCnt_q <= objCnt_d;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start && armed_q) begin
                        state_q  <= SCAN;
                        armed_q  <= 1'b0;
                        rd_q     <= 1'b1;
                        addr_q   <= 14'd0;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b0;
                        maxVal_q <= 8'd0;
                        maxRow_q <= 7'd0;
                        maxCol_q <= 7'd0;
                        objCnt_q <= 15'd0;
                    end
                end
                SCAN: begin
                    addr_q <= addr_q + 14'd1;
                    if (addr_q == 14'd16382) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle still reads address 16383; the second one finishes.
                    if (rd_q) begin
                        rd_q <= 1'b0;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_rd   = rd_q;
    assign res_addr = addr_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign max_val  = maxVal_q;
    assign max_row  = maxRow_q;
    assign max_col  = maxCol_q;
    assign obj_cnt  = objCnt_q;

endmodule
